cp0_regfile: RTL
================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameter HW_INT_N, default 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_N-1:2].
REQ-002 Parameter COUNT_DIV, default 2, clock cycles per Count increment (1..16).
REQ-003 Parameter EXC_VECTOR, default 32'hBFC0_0380, exception/interrupt entry address.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 we / waddr / wdata  in  1/5/32  MTC0 write strobe, register number, data.
REQ-007 raddr  in  5  MFC0 register number; rdata out 32, combinational read of current register value.
REQ-008 hw_int  in  HW_INT_N  level-sensitive hardware interrupt requests.
REQ-009 exc_valid / exc_code / exc_pc / exc_badvaddr / exc_bd  in  1/5/32/32/1  synchronous exception report from commit stage (valid, ExcCode, faulting PC, bad address, delay-slot flag).
REQ-010 eret  in  1  ERET committing this cycle.
REQ-011 flush / flush_pc  out  1/32  registered one-cycle redirect pulse and target.
REQ-012 int_pending  out  1  combinational: interrupt would be taken this cycle.

Function
REQ-013 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other raddr read 0, other waddr ignored.
REQ-014 Status writable bits IM[15:8], EXL[1], IE[0]; BEV[22] hard 1; remaining bits read 0.
REQ-015 Cause writable bits IP[9:8] only; IP[15:10] sampled every cycle from interrupt sources; BD[31], TI[30], ExcCode[6:2] hardware-only.
REQ-016 Prescaler counts 0..COUNT_DIV-1; Count increments (mod 2^32) when prescaler wraps; write to Count loads wdata and clears prescaler.
REQ-017 int_pending = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP).
REQ-018 Event priority per cycle: interrupt > exc_valid > eret > MTC0 write; a lower-priority event that loses is discarded, except MTC0 write also occurs with no event.
REQ-019 Interrupt/exception entry: if EXL=0, EPC = exc_bd ? exc_pc-4 : exc_pc and BD = exc_bd; if EXL=1, EPC and BD unchanged; ExcCode = 0 (interrupt) or exc_code; EXL set; next cycle flush=1, flush_pc=EXC_VECTOR.
REQ-020 BadVAddr loads exc_badvaddr only on taken exception with exc_code AdEL(4) or AdES(5).
REQ-021 ERET: EXL cleared; next cycle flush=1, flush_pc = EPC value before this cycle.
REQ-022 flush is high for exactly one cycle per taken event; back-to-back events give back-to-back pulses.
REQ-023 Interrupt with exc_valid=0 uses exc_pc/exc_bd of the instruction at commit; it is taken only in a cycle with exc_valid=1 or with an instruction committing (caller holds exc_pc valid).

Reset
REQ-024 On rst: Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0, flush=0, flush_pc=0.
REQ-025 rst asserted mid-operation overrides any event in the same cycle; a pending flush pulse is cancelled.

Configuration
REQ-026 Macro CP0_TIMER_INT_EN: when defined, Compare write clears TI; TI sets on the cycle Count increments to equal Compare; IP[7] = TI | hw_int[5] (if HW_INT_N=6).
REQ-027 Without CP0_TIMER_INT_EN: Compare is a plain read/write register, TI reads 0, IP[7] driven from hw_int[5] only.

Verification
REQ-028 Reset, then read Status -> rdata=32'h0040_0000; Cause/EPC/Count read 0.
REQ-029 COUNT_DIV=2, write Count=5, wait 6 cycles -> Count reads 8.
REQ-030 Status=32'h0000_0401, hw_int[0]=1, exc_pc=32'h8000_0100, exc_bd=1 -> next cycle flush=1, flush_pc=32'hBFC0_0380, EPC=32'h8000_00FC, Cause.BD=1, ExcCode=0, EXL=1.
REQ-031 exc_valid with exc_code=4, exc_badvaddr=32'h0000_1003, same cycle as MTC0 Status write -> BadVAddr=32'h0000_1003, Status write discarded, EXL=1.
REQ-032 EXL=1, EPC=32'h8000_0200, eret=1 -> next cycle flush=1, flush_pc=32'h8000_0200, EXL=0.
REQ-033 CP0_TIMER_INT_EN defined, Compare=10, Status=32'h0000_8001 -> Count reaches 10, TI=1, interrupt taken; write Compare -> TI=0.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: MTC0/MFC0 access, interrupt lines, commit-stage exception/ERET report
// and pipeline redirect of the CP0 register file.
interface cp0_regfile_if #(
  parameter int unsigned HW_INT_N = 6
);
  logic                i_we;
  logic [4:0]          i_waddr;
  logic [31:0]         i_wdata;
  logic [4:0]          i_raddr;
  logic [31:0]         o_rdata;
  logic [HW_INT_N-1:0] i_hw_int;
  logic                i_exc_valid;
  logic [4:0]          i_exc_code;
  logic [31:0]         i_exc_pc;
  logic [31:0]         i_exc_badvaddr;
  logic                i_exc_bd;
  logic                i_eret;
  logic                o_flush;
  logic [31:0]         o_flush_pc;
  logic                o_int_pending;

  modport master (
    output i_we, i_waddr, i_wdata, i_raddr, i_hw_int,
           i_exc_valid, i_exc_code, i_exc_pc, i_exc_badvaddr, i_exc_bd, i_eret,
    input  o_rdata, o_flush, o_flush_pc, o_int_pending
  );

  modport slave (
    input  i_we, i_waddr, i_wdata, i_raddr, i_hw_int,
           i_exc_valid, i_exc_code, i_exc_pc, i_exc_badvaddr, i_exc_bd, i_eret,
    output o_rdata, o_flush, o_flush_pc, o_int_pending
  );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC) with interrupt,
// exception and ERET sequencing. Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt.
module cp0_regfile #(
  parameter int unsigned HW_INT_N   = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic         i_clk,
  input  logic         i_rst,
  cp0_regfile_if.slave bus
);

  localparam int unsigned PRESC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] EXC_ADEL     = 5'd4;
  localparam logic [4:0] EXC_ADES     = 5'd5;

  logic [PRESC_W-1:0]  r_presc;
  logic [31:0]         r_count;
  logic [31:0]         r_compare;
  logic [31:0]         r_epc;
  logic [31:0]         r_badvaddr;
  logic [31:0]         r_flush_pc;
  logic                r_flush;
  logic                r_ie;
  logic                r_exl;
  logic [7:0]          r_im;
  logic                r_bd;
  logic [4:0]          r_exccode;
  logic [1:0]          r_ip_sw;
  logic [5:0]          r_ip_hw;

  logic [HW_INT_N-1:0] w_hw_int;
  logic [5:0]          w_ip_hw_next;
  logic                w_ti;
  logic                w_int_pending;
  logic                w_take_int;
  logic                w_take_exc;
  logic                w_take_eret;
  logic                w_entry;
  logic                w_mtc0;
  logic                w_count_wr;
  logic                w_compare_wr;
  logic                w_tick;
  logic [31:0]         w_count_inc;
  logic [31:0]         w_epc_entry;
  logic [31:0]         w_rdata;

`ifdef CP0_TIMER_INT_EN
  logic                r_ti;
  assign w_ti = r_ti;
`else
  assign w_ti = 1'b0;
`endif

  assign w_hw_int = bus.i_hw_int;

  // Cause.IP[15:10] sources, re-sampled every cycle
  always_comb begin
    w_ip_hw_next = 6'(w_hw_int);
`ifdef CP0_TIMER_INT_EN
    w_ip_hw_next[5] = w_ip_hw_next[5] | r_ti;
`endif
  end

  // Event arbitration: interrupt > exception > ERET > MTC0
  assign w_int_pending = r_ie & ~r_exl & (|(r_im & {r_ip_hw, r_ip_sw}));
  assign w_take_int    = w_int_pending;
  assign w_take_exc    = bus.i_exc_valid & ~w_take_int;
  assign w_take_eret   = bus.i_eret & ~w_take_int & ~bus.i_exc_valid;
  assign w_entry       = w_take_int | w_take_exc;
  assign w_mtc0        = bus.i_we & ~w_entry & ~w_take_eret;
  assign w_count_wr    = w_mtc0 & (bus.i_waddr == REG_COUNT);
  assign w_compare_wr  = w_mtc0 & (bus.i_waddr == REG_COMPARE);

  assign w_tick        = (r_presc == PRESC_LAST);
  assign w_count_inc   = r_count + 32'd1;
  assign w_epc_entry   = bus.i_exc_bd ? (bus.i_exc_pc - 32'd4) : bus.i_exc_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_flush_pc <= '0;
      r_flush    <= 1'b0;
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im       <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
    end else begin
      r_ip_hw <= w_ip_hw_next;
      r_flush <= w_entry | w_take_eret;
      if (w_entry) begin
        r_flush_pc <= EXC_VECTOR;
      end else if (w_take_eret) begin
        r_flush_pc <= r_epc;
      end

      if (w_count_wr) begin
        r_count <= bus.i_wdata;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end

      // Nested entry (EXL already set) keeps the original EPC/BD
      if (w_entry) begin
        r_exl     <= 1'b1;
        r_exccode <= w_take_int ? 5'd0 : bus.i_exc_code;
        if (!r_exl) begin
          r_epc <= w_epc_entry;
          r_bd  <= bus.i_exc_bd;
        end
        if (w_take_exc && (bus.i_exc_code == EXC_ADEL || bus.i_exc_code == EXC_ADES)) begin
          r_badvaddr <= bus.i_exc_badvaddr;
        end
      end else if (w_take_eret) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        case (bus.i_waddr)
          REG_COMPARE: r_compare <= bus.i_wdata;
          REG_STATUS: begin
            r_im  <= bus.i_wdata[15:8];
            r_exl <= bus.i_wdata[1];
            r_ie  <= bus.i_wdata[0];
          end
          REG_CAUSE:   r_ip_sw <= bus.i_wdata[9:8];
          REG_EPC:     r_epc   <= bus.i_wdata;
          default:     ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  // TI sets only when Count steps onto Compare; a Compare write clears it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ti <= 1'b0;
    end else if (w_compare_wr) begin
      r_ti <= 1'b0;
    end else if (!w_count_wr && w_tick && (w_count_inc == r_compare)) begin
      r_ti <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_rdata = 32'd0;
    case (bus.i_raddr)
      REG_BADVADDR: w_rdata = r_badvaddr;
      REG_COUNT:    w_rdata = r_count;
      REG_COMPARE:  w_rdata = r_compare;
      REG_STATUS:   w_rdata = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
      REG_CAUSE:    w_rdata = {r_bd, w_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
      REG_EPC:      w_rdata = r_epc;
      default:      w_rdata = 32'd0;
    endcase
  end

  assign bus.o_rdata       = w_rdata;
  assign bus.o_int_pending = w_int_pending;
  assign bus.o_flush       = r_flush;
  assign bus.o_flush_pc    = r_flush_pc;

endmodule
